// File: rtl/dcp_run_ctrl.sv
`timescale 1ns/1ps
// Debug-panel CPU clock sequencer: issues fixed-width clk_cpu pulses for
// single-step and run-to-breakpoint commands, checking stop conditions after each pulse.
module dcp_run_ctrl #(
    parameter int HALF = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_req,
    input  logic        run_req,
    input  logic        stop_req,
    input  logic [31:0] bp1,
    input  logic [31:0] bp2,
    input  logic [1:0]  bp_en,
    input  logic [31:0] pc_chk,
    input  logic [31:0] max_cyc,
    output logic        clk_cpu,
    output logic        busy,
    output logic        done,
    output logic [2:0]  cause,
    output logic [31:0] cyc_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HIGH  = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic MODE_STEP = 1'b0;
    localparam logic MODE_RUN  = 1'b1;

    localparam logic [7:0] PH_LAST = 8'(HALF - 1);

    localparam logic [2:0] C_STEP  = 3'd0;
    localparam logic [2:0] C_BP1   = 3'd1;
    localparam logic [2:0] C_BP2   = 3'd2;
    localparam logic [2:0] C_STOP  = 3'd3;
    localparam logic [2:0] C_LIMIT = 3'd4;

    logic [2:0]  state;
    logic [7:0]  phase;
    logic        mode;
    logic        stop_latch;
    logic [31:0] cyc_next;
    logic        stop_hit;
    logic [2:0]  stop_cause;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Stop conditions in priority order; the limit compares against the count after this pulse.
    always_comb begin
        cyc_next   = cyc_cnt + 32'd1;
        stop_hit   = 1'b1;
        stop_cause = C_STEP;
        if (mode == MODE_STEP) begin
            stop_cause = C_STEP;
        end else if (stop_latch) begin
            stop_cause = C_STOP;
        end else if (bp_en[0] && (pc_chk == bp1)) begin
            stop_cause = C_BP1;
        end else if (bp_en[1] && (pc_chk == bp2)) begin
            stop_cause = C_BP2;
        end else if ((max_cyc != 32'd0) && (cyc_next == max_cyc)) begin
            stop_cause = C_LIMIT;
        end else begin
            stop_hit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            phase      <= 8'd0;
            mode       <= MODE_STEP;
            stop_latch <= 1'b0;
            clk_cpu    <= 1'b0;
            cause      <= C_STEP;
            cyc_cnt    <= 32'd0;
        end else begin
            if (state == S_DONE) begin
                stop_latch <= 1'b0;
            end else if (stop_req && busy && (mode == MODE_RUN)) begin
                stop_latch <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (step_req || run_req) begin
                        state   <= S_HIGH;
                        mode    <= step_req ? MODE_STEP : MODE_RUN;
                        clk_cpu <= 1'b1;
                        phase   <= PH_LAST;
                        cyc_cnt <= 32'd0;
                        cause   <= C_STEP;
                    end
                end
                S_HIGH: begin
                    if (phase == 8'd0) begin
                        state   <= S_LOW;
                        clk_cpu <= 1'b0;
                        phase   <= PH_LAST;
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end
                S_LOW: begin
                    if (phase == 8'd0) begin
                        state <= S_CHECK;
                    end else begin
                        phase <= phase - 8'd1;
                    end
                end
                S_CHECK: begin
                    cyc_cnt <= cyc_next;
                    if (stop_hit) begin
                        state <= S_DONE;
                        cause <= stop_cause;
                    end else begin
                        state   <= S_HIGH;
                        clk_cpu <= 1'b1;
                        phase   <= PH_LAST;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcp_run_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for dcp_run_ctrl: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever done is presented.
module tb_dcp_run_ctrl;

    localparam int HALF = 2;
    localparam int CPC  = 2 * HALF + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_req = 1'b0;
    logic        run_req = 1'b0;
    logic        stop_req = 1'b0;
    logic [31:0] bp1 = 32'd0;
    logic [31:0] bp2 = 32'd0;
    logic [1:0]  bp_en = 2'b00;
    logic [31:0] pc_chk;
    logic [31:0] max_cyc = 32'd0;
    logic        clk_cpu;
    logic        busy;
    logic        done;
    logic [2:0]  cause;
    logic [31:0] cyc_cnt;

    typedef struct {
        logic [2:0]  cause;
        logic [31:0] cnt;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    int          pulse_cnt = 0;
    int          pulse_base = 0;
    logic [31:0] pc_base = 32'd0;
    int          e;

    dcp_run_ctrl #(.HALF(HALF)) dut (
        .clk(clk), .rst(rst), .step_req(step_req), .run_req(run_req),
        .stop_req(stop_req), .bp1(bp1), .bp2(bp2), .bp_en(bp_en),
        .pc_chk(pc_chk), .max_cyc(max_cyc), .clk_cpu(clk_cpu), .busy(busy),
        .done(done), .cause(cause), .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // CPU model: PC advances by 4 on every clk_cpu rise.
    always @(posedge clk_cpu) pulse_cnt++;
    assign pc_chk = pc_base + 32'(4 * (pulse_cnt - pulse_base));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, expected done=0 at edge %0d", edge_cnt);
            end else begin
                exp_t x;
                x = sb.pop_front();
                checkOutput("done_cause", {29'd0, cause}, {29'd0, x.cause});
                checkOutput("done_cyc_cnt", cyc_cnt, x.cnt);
                checkOutput("done_edge", 32'(edge_cnt), 32'(x.at));
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic r, input logic p, output int at);
        @(posedge clk);
        #1;
        step_req = s;
        run_req  = r;
        stop_req = p;
        at = edge_cnt;
        @(posedge clk);
        #1;
        step_req = 1'b0;
        run_req  = 1'b0;
        stop_req = 1'b0;
    endtask

    task automatic expectDone(input logic [2:0] c, input int n, input int at);
        exp_t x;
        x.cause = c;
        x.cnt   = 32'(n);
        x.at    = at + n * CPC + 1;
        sb.push_back(x);
    endtask

    task automatic setRun(input logic [31:0] b1, input logic [31:0] b2, input logic [1:0] en,
                          input logic [31:0] mx, input logic [31:0] pcb);
        bp1        = b1;
        bp2        = b2;
        bp_en      = en;
        max_cyc    = mx;
        pc_base    = pcb;
        pulse_base = pulse_cnt;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got busy=%0b pending=%0d, expected idle", busy, sb.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic doStepTest();
        int at;
        int k;
        applyStimulus(1'b1, 1'b0, 1'b0, at);
        expectDone(3'd0, 1, at);
        repeat (7) begin
            @(negedge clk);
            k = edge_cnt - at;
            checkOutput("step_clk_cpu", {31'd0, clk_cpu}, {31'd0, (k >= 1 && k <= HALF)});
            checkOutput("step_busy", {31'd0, busy}, {31'd0, (k >= 1 && k <= CPC + 1)});
        end
        waitIdle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_clk_cpu", {31'd0, clk_cpu}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_cause", {29'd0, cause}, 32'd0);
        checkOutput("rst_cyc_cnt", cyc_cnt, 32'd0);

        $display("[TB] single step");
        doStepTest();

        $display("[TB] run to bp1");
        setRun(32'h300C, 32'h0, 2'b01, 32'd0, 32'h3000);
        applyStimulus(1'b0, 1'b1, 1'b0, e);
        expectDone(3'd1, 3, e);
        waitIdle();

        $display("[TB] breakpoint priority");
        setRun(32'h3008, 32'h3008, 2'b11, 32'd0, 32'h3000);
        applyStimulus(1'b0, 1'b1, 1'b0, e);
        expectDone(3'd1, 2, e);
        waitIdle();
        setRun(32'h3008, 32'h3008, 2'b10, 32'd0, 32'h3000);
        applyStimulus(1'b0, 1'b1, 1'b0, e);
        expectDone(3'd2, 2, e);
        waitIdle();

        $display("[TB] cycle limit");
        setRun(32'h0, 32'h0, 2'b00, 32'd5, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, e);
        expectDone(3'd4, 5, e);
        waitIdle();

        $display("[TB] stop during second pulse");
        setRun(32'h0, 32'h0, 2'b00, 32'd0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, e);
        expectDone(3'd3, 2, e);
        repeat (5) @(posedge clk);
        #1 stop_req = 1'b1;
        @(posedge clk);
        #1 stop_req = 1'b0;
        @(negedge clk);
        checkOutput("stop_pulse_high", {31'd0, clk_cpu}, 32'd1);
        checkOutput("stop_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("stop_pulse_low", {31'd0, clk_cpu}, 32'd0);
        waitIdle();

        $display("[TB] step and run together");
        applyStimulus(1'b1, 1'b1, 1'b0, e);
        expectDone(3'd0, 1, e);
        waitIdle();

        $display("[TB] run while busy");
        applyStimulus(1'b1, 1'b0, 1'b0, e);
        expectDone(3'd0, 1, e);
        @(posedge clk);
        #1 run_req = 1'b1;
        @(posedge clk);
        #1 run_req = 1'b0;
        waitIdle();

        $display("[TB] stop in idle");
        setRun(32'h0, 32'h0, 2'b00, 32'd3, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, e);
        repeat (3) @(posedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, e);
        expectDone(3'd4, 3, e);
        waitIdle();

        $display("[TB] reset mid-run");
        setRun(32'h0, 32'h0, 2'b00, 32'd0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, e);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_pre_clk_cpu", {31'd0, clk_cpu}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("midrst_clk_cpu", {31'd0, clk_cpu}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_cyc_cnt", cyc_cnt, 32'd0);
        checkOutput("midrst_done", {31'd0, done}, 32'd0);
        repeat (4) @(negedge clk);
        doStepTest();

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
